// File: rtl/mm_pkg.sv
// Shared MasterMind definitions: code geometry, colour/code types and the code-generator FSM states.
// Game control and feedback scoring import the same package.
package mm_pkg;

    localparam int unsigned PEGS   = 4;
    localparam int unsigned COLORS = 6;
    localparam int unsigned CW     = $clog2(COLORS);

    typedef logic [CW-1:0]      color_t;
    typedef color_t [PEGS-1:0]  code_t;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StCheck,
        StDone
    } gen_state_e;

endpackage

// File: rtl/color_reduce.sv
// Maps one 32-bit RNG word to a colour in [0, COLORS) without modulo bias.
// Words at or above the largest multiple of COLORS are flagged out of range.
module color_reduce
    import mm_pkg::*;
(
    input  logic [31:0] rng_res,
    output color_t      colour,
    output logic        in_range
);

    localparam logic [63:0] SPAN  = 64'd1 << 32;
    // 33 bits so that COLORS a power of two gives LIMIT = 2^32 (everything in range)
    localparam logic [32:0] LIMIT = 33'((SPAN / 64'(COLORS)) * 64'(COLORS));

    always_comb begin
        in_range = ({1'b0, rng_res} < LIMIT);
        colour   = color_t'(rng_res % 32'(COLORS));
    end

endmodule

// File: rtl/secret_code_gen.sv
// Builds the secret code peg by peg from RNG draws, with optional distinct-colour rejection
// and a deterministic fallback once a peg has used up its draw budget.
module secret_code_gen
    import mm_pkg::*;
#(
    parameter int unsigned ALLOW_REPEAT = 1,
    parameter int unsigned MAX_TRIES    = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 rng_en,
    input  logic [31:0]          rng_res,
    output logic                 busy,
    output logic [PEGS*CW-1:0]   code,
    output logic                 code_valid
);

    localparam int unsigned   TW       = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam int unsigned   PW       = (PEGS > 1) ? $clog2(PEGS) : 1;
    localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRIES - 1);
    localparam logic [PW-1:0] PEG_LAST = PW'(PEGS - 1);
    localparam logic          UNIQUE   = (ALLOW_REPEAT == 0);

    gen_state_e    state_q, state_d;
    code_t         code_q, code_d;
    logic          code_valid_q, code_valid_d;
    logic [PW-1:0] peg_q, peg_d;
    logic [TW-1:0] try_q, try_d;

    color_t draw_colour;
    logic   draw_in_range;

    color_reduce u_color_reduce (
        .rng_res  (rng_res),
        .colour   (draw_colour),
        .in_range (draw_in_range)
    );

    // Colours already taken by pegs below the current index
    logic [COLORS-1:0] used;
    logic              dup_hit;
    color_t            fallback;
    logic              fallback_found;

    always_comb begin
        used = '0;
        for (int unsigned i = 0; i < PEGS; i++) begin
            if (PW'(i) < peg_q) begin
                used[code_q[PW'(i)]] = 1'b1;
            end
        end
        dup_hit = used[draw_colour];

        fallback       = '0;
        fallback_found = 1'b0;
        for (int unsigned c = 0; c < COLORS; c++) begin
            if (!fallback_found && !used[CW'(c)]) begin
                fallback       = CW'(c);
                fallback_found = 1'b1;
            end
        end
    end

    logic   reject;
    logic   take;
    color_t pick;

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        code_valid_d = code_valid_q;
        peg_d        = peg_q;
        try_d        = try_q;
        rng_en       = 1'b0;
        busy         = 1'b0;
        reject       = 1'b0;
        take         = 1'b0;
        pick         = draw_colour;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StReq;
                    code_valid_d = 1'b0;
                    peg_d        = '0;
                    try_d        = '0;
                end
            end
            StReq: begin
                busy    = 1'b1;
                rng_en  = 1'b1;
                state_d = StCheck;
            end
            StCheck: begin
                busy   = 1'b1;
                reject = !draw_in_range || (UNIQUE && dup_hit);
                if (!reject) begin
                    take = 1'b1;
                end else if (UNIQUE && (try_q == TRY_LAST)) begin
                    take = 1'b1;
                    pick = fallback;
                end

                if (take) begin
                    code_d[peg_q] = pick;
                    try_d         = '0;
                    if (peg_q == PEG_LAST) begin
                        state_d = StDone;
                    end else begin
                        peg_d   = peg_q + 1'b1;
                        state_d = StReq;
                    end
                end else begin
                    // Saturate so an endless bias-reject run cannot wrap the counter
                    if (try_q != TRY_LAST) begin
                        try_d = try_q + 1'b1;
                    end
                    state_d = StReq;
                end
            end
            StDone: begin
                code_valid_d = 1'b1;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            peg_q        <= '0;
            try_q        <= '0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            peg_q        <= peg_d;
            try_q        <= try_d;
        end
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;

endmodule

// File: tb/tb_secret_code_gen.sv
// Bench for secret_code_gen: one instance with repeats allowed (index 0), one requiring
// distinct colours (index 1), each fed by a scripted RNG stub.
module tb_secret_code_gen;
    import mm_pkg::*;

    localparam int CODE_W    = PEGS * CW;
    localparam int MAX_TRIES = 256;
    localparam int MEM_SZ    = 2048;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_s [2];
    logic              en_s    [2];
    logic [31:0]       rr      [2];
    logic              busy_s  [2];
    logic [CODE_W-1:0] code_s  [2];
    logic              cv_s    [2];

    always #5 clk = ~clk;

    secret_code_gen #(.ALLOW_REPEAT(1), .MAX_TRIES(MAX_TRIES)) u_rep (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .rng_en(en_s[0]), .rng_res(rr[0]),
        .busy(busy_s[0]), .code(code_s[0]), .code_valid(cv_s[0])
    );

    secret_code_gen #(.ALLOW_REPEAT(0), .MAX_TRIES(MAX_TRIES)) u_uni (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .rng_en(en_s[1]), .rng_res(rr[1]),
        .busy(busy_s[1]), .code(code_s[1]), .code_valid(cv_s[1])
    );

    // RNG stub: on each rng_en edge, present the next scripted word and count the pulse
    logic [31:0] mem [2][MEM_SZ];
    int          idx [2] = '{0, 0};

    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (en_s[s]) begin
                rr[s]  <= mem[s][idx[s] % MEM_SZ];
                idx[s] <= idx[s] + 1;
            end
        end
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] vec [$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int sel);
        for (int i = 0; i < 1024; i++) begin
            mem[sel][(idx[sel] + i) % MEM_SZ] = (i < vec.size()) ? vec[i] : 32'd0;
        end
    endtask

    // Reference: draw words in order, apply bias limit, distinctness and the try budget
    function automatic void model(input bit allow_rep, output logic [CODE_W-1:0] ecode,
                                  output int nd);
        longint unsigned limit;
        longint unsigned r;
        int pegv [PEGS];
        int p, tries, k, c;
        bit ok, found, taken;
        limit = ((64'd1 << 32) / COLORS) * COLORS;
        p = 0; tries = 0; k = 0;
        while (p < PEGS) begin
            r = (k < vec.size()) ? longint'(vec[k]) : 0;
            k++;
            c  = int'(r % COLORS);
            ok = (r < limit);
            if (ok && !allow_rep) begin
                for (int j = 0; j < p; j++) if (pegv[j] == c) ok = 0;
            end
            if (!ok && !allow_rep && tries == MAX_TRIES - 1) begin
                found = 0;
                for (int cc = 0; cc < COLORS; cc++) begin
                    taken = 0;
                    for (int j = 0; j < p; j++) if (pegv[j] == cc) taken = 1;
                    if (!found && !taken) begin
                        c = cc;
                        found = 1;
                    end
                end
                ok = 1;
            end
            if (ok) begin
                pegv[p] = c;
                p++;
                tries = 0;
            end else begin
                tries++;
            end
        end
        nd = k;
        ecode = '0;
        for (int i = 0; i < PEGS; i++) ecode[i*CW +: CW] = CW'(pegv[i]);
    endfunction

    // Full generation: start pulse, latency, pulse count, final code
    task automatic run_check(input int sel, input logic [CODE_W-1:0] ecode, input int end_nd,
                             input string nm);
        int base, edges;
        load(sel);
        base = idx[sel];
        start_s[sel] = 1'b1;
        tick();
        start_s[sel] = 1'b0;
        edges = 1;
        check({nm, "_cv_clear"}, 64'(cv_s[sel]), 64'd0);
        check({nm, "_busy_run"}, 64'(busy_s[sel]), 64'd1);
        while (!cv_s[sel] && edges < 5000) begin
            tick();
            edges++;
        end
        check({nm, "_latency"}, 64'(edges), 64'(2 * end_nd + 2));
        check({nm, "_code"}, 64'(code_s[sel]), 64'(ecode));
        check({nm, "_pulses"}, 64'(idx[sel] - base), 64'(end_nd));
        check({nm, "_busy_end"}, 64'(busy_s[sel]), 64'd0);
    endtask

    task automatic check_reset(input string nm);
        for (int s = 0; s < 2; s++) begin
            check({nm, "_code"}, 64'(code_s[s]), 64'd0);
            check({nm, "_cv"}, 64'(cv_s[s]), 64'd0);
            check({nm, "_busy"}, 64'(busy_s[s]), 64'd0);
            check({nm, "_rng_en"}, 64'(en_s[s]), 64'd0);
        end
    endtask

    typedef struct {
        int                sel;
        int                n;
        logic [7:0][31:0]  d;
        logic [CODE_W-1:0] ecode;
        int                nd;
        string             nm;
    } vec_t;

    function automatic logic [7:0][31:0] d8(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
        logic [7:0][31:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
        return r;
    endfunction

    vec_t tbl [6];

    initial begin
        logic [CODE_W-1:0] mcode;
        int                mnd;
        int                base;

        // Pegs packed CW=3 bits each, peg 0 in the low bits
        tbl[0] = '{0, 4, d8(7, 12, 5, 6, 0, 0, 0, 0), 12'h141, 4, "rep_basic"};
        tbl[1] = '{0, 5, d8(32'hFFFFFFFE, 3, 1, 2, 4, 0, 0, 0), 12'h88B, 5, "rep_bias"};
        tbl[2] = '{0, 5, d8(32'hFFFFFFFB, 32'hFFFFFFFF, 0, 6, 2, 0, 0, 0), 12'h405, 5, "rep_edge"};
        tbl[3] = '{1, 5, d8(1, 7, 2, 3, 4, 0, 0, 0), 12'h8D1, 5, "uni_dup"};
        tbl[4] = '{1, 8, d8(5, 32'hFFFFFFFC, 5, 32'hFFFFFFFB, 0, 11, 4, 9), 12'h705, 8,
                   "uni_mix"};
        tbl[5] = '{1, 0, d8(0, 0, 0, 0, 0, 0, 0, 0), 12'h688, 1 + 3 * MAX_TRIES, "uni_fallback"};

        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        check_reset("reset");
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a generation
        vec = '{7, 12, 5, 6};
        load(0);
        load(1);
        start_s[0] = 1'b1;
        start_s[1] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        check_reset("midreset");
        rst_n = 1'b1;
        tick();

        for (int t = 0; t < 6; t++) begin
            vec.delete();
            for (int i = 0; i < tbl[t].n; i++) vec.push_back(tbl[t].d[i]);
            run_check(tbl[t].sel, tbl[t].ecode, tbl[t].nd, tbl[t].nm);
        end

        // start while busy and while in DONE must be ignored
        vec = '{7, 12, 5, 6};
        load(0);
        base = idx[0];
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        tick();
        tick();
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        for (int e = 4; e < 9; e++) tick();
        check("done_busy_low", 64'(busy_s[0]), 64'd0);
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        check("ign_cv", 64'(cv_s[0]), 64'd1);
        check("ign_code", 64'(code_s[0]), 64'h141);
        tick();
        tick();
        tick();
        check("ign_cv_hold", 64'(cv_s[0]), 64'd1);
        check("ign_busy", 64'(busy_s[0]), 64'd0);
        check("ign_pulses", 64'(idx[0] - base), 64'd4);

        // Random draws against the reference model, both variants
        for (int it = 0; it < 24; it++) begin
            int sel;
            sel = it % 2;
            vec.delete();
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(7) == 0) vec.push_back(32'hFFFFFFF0 | 32'($urandom_range(15)));
                else vec.push_back($urandom);
            end
            model(sel == 0, mcode, mnd);
            run_check(sel, mcode, mnd, $sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
